uart_frame_receiver: RTL and testbench

- Receive side of the SoC serial link: deserializes the 8E1 frames the SoC UART transmits, and the frames the UART driver sends into it.
- Frame format: start(0), 8 data bits LSB first, optional even parity bit (=^data), stop(1).
- Used as the bench-side monitor on io_uart_tx and as a reusable RX core for uart_ctrl.
- Received bytes are presented on a valid/ready stream with per-byte error flags.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_rx_fifo.sv | 56 +++++
 rtl/uart_frame_receiver.sv | 209 ++++++++++++++++++++
 tb/tb_uart_frame_receiver.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

    localparam int UART_DATA_BITS   = 8;
    localparam int UART_MIN_DIVISOR = 3;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_IDLE
    } rx_state_e;

    typedef struct packed {
        logic [UART_DATA_BITS-1:0] data;
        logic                      parity_error;
        logic                      framing_error;
    } rx_word_t;

    function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive FIFO of rx_word_t entries; pointers carry an extra wrap bit.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     i_push,
    input  rx_word_t i_word,
    input  logic     i_pop,
    output rx_word_t o_head,
    output logic     o_valid,
    output logic     o_full
);

    localparam int AW = $clog2(DEPTH);

    rx_word_t    r_mem [DEPTH];
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic        w_full;
    logic        w_empty;
    logic        w_wr_en;
    logic        w_rd_en;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_rd_en = i_pop & ~w_empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_wr_en = i_push & (~w_full | w_rd_en);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_wr_en) begin
                r_mem[r_wr_ptr[AW-1:0]] <= i_word;
                r_wr_ptr                <= r_wr_ptr + (AW+1)'(1);
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            end
        end
    end

    assign o_head  = r_mem[r_rd_ptr[AW-1:0]];
    assign o_valid = ~w_empty;
    assign o_full  = w_full;

endmodule

// File: rtl/uart_frame_receiver.sv
// UART frame receiver (start, 8 data LSB first, optional even parity, stop).
// Define UART_RX_FIFO_EN to replace the single output register with a FIFO.
module uart_frame_receiver
    import uart_pkg::*;
#(
    parameter int DIVISOR_WIDTH = 16,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     io_rx,
    input  logic [DIVISOR_WIDTH-1:0] io_divisor,
    input  logic                     io_parity_en,
    output logic                     io_rsp_valid,
    input  logic                     io_rsp_ready,
    output logic [7:0]               io_rsp_data,
    output logic                     io_rsp_parity_error,
    output logic                     io_rsp_framing_error,
    output logic                     io_overrun,
    input  logic                     io_overrun_clear,
    output logic                     io_busy
);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_check
        $error("FIFO_DEPTH must be a power of 2 and at least 2");
    end

    logic                     r_rx_meta;
    logic                     r_rx_s;
    rx_state_e                r_state;
    rx_state_e                w_state_nxt;
    logic [DIVISOR_WIDTH-1:0] r_cnt;
    logic [DIVISOR_WIDTH-1:0] w_cnt_nxt;
    logic [DIVISOR_WIDTH-1:0] r_div;
    logic [DIVISOR_WIDTH-1:0] w_div_in;
    logic                     r_par_en;
    logic [2:0]               r_idx;
    logic [2:0]               w_idx_nxt;
    logic [7:0]               r_data;
    logic [7:0]               w_data_nxt;
    logic                     r_perr;
    logic                     w_perr_nxt;
    logic                     w_timeout;
    logic                     w_start;
    logic                     w_push;
    rx_word_t                 w_word;
    rx_word_t                 w_rsp_word;
    logic                     w_rsp_valid;
    logic                     w_pop;
    logic                     w_drop;
    logic                     r_overrun;

    // Sync flops reset high so reset can never look like a start bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= io_rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    assign w_div_in  = (io_divisor < DIVISOR_WIDTH'(UART_MIN_DIVISOR)) ?
                       DIVISOR_WIDTH'(UART_MIN_DIVISOR) : io_divisor;
    assign w_timeout = (r_cnt == '0);
    assign w_start   = (r_state == IDLE) && !r_rx_s;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = w_timeout ? r_cnt : r_cnt - DIVISOR_WIDTH'(1);
        w_idx_nxt   = r_idx;
        w_data_nxt  = r_data;
        w_perr_nxt  = r_perr;
        w_push      = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_perr_nxt = 1'b0;
                if (!r_rx_s) begin
                    w_cnt_nxt   = w_div_in >> 1;
                    w_state_nxt = START;
                end
            end
            START: begin
                if (w_timeout) begin
                    if (r_rx_s) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_cnt_nxt   = r_div;
                        w_idx_nxt   = '0;
                        w_state_nxt = DATA;
                    end
                end
            end
            DATA: begin
                if (w_timeout) begin
                    w_data_nxt[r_idx] = r_rx_s;
                    w_cnt_nxt         = r_div;
                    w_idx_nxt         = r_idx + 3'd1;
                    if (r_idx == 3'(UART_DATA_BITS - 1)) begin
                        w_state_nxt = r_par_en ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (w_timeout) begin
                    w_perr_nxt  = r_rx_s ^ even_parity(r_data);
                    w_cnt_nxt   = r_div;
                    w_state_nxt = STOP;
                end
            end
            STOP: begin
                if (w_timeout) begin
                    w_push      = 1'b1;
                    w_state_nxt = r_rx_s ? IDLE : WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                if (r_rx_s) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_div    <= '0;
            r_par_en <= 1'b0;
            r_idx    <= '0;
            r_data   <= '0;
            r_perr   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_data  <= w_data_nxt;
            r_perr  <= w_perr_nxt;
            if (w_start) begin
                r_div    <= w_div_in;
                r_par_en <= io_parity_en;
            end
        end
    end

    assign w_word = '{data: r_data, parity_error: r_perr, framing_error: ~r_rx_s};
    assign w_pop  = w_rsp_valid & io_rsp_ready;

`ifdef UART_RX_FIFO_EN
    logic w_fifo_full;

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_word  (w_word),
        .i_pop   (w_pop),
        .o_head  (w_rsp_word),
        .o_valid (w_rsp_valid),
        .o_full  (w_fifo_full)
    );

    assign w_drop = w_push & w_fifo_full & ~w_pop;
`else
    rx_word_t r_word;
    logic     r_valid;

    assign w_drop = w_push & r_valid & ~io_rsp_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_word  <= '0;
            r_valid <= 1'b0;
        end else if (w_push && !w_drop) begin
            r_word  <= w_word;
            r_valid <= 1'b1;
        end else if (w_pop) begin
            r_valid <= 1'b0;
        end
    end

    assign w_rsp_word  = r_word;
    assign w_rsp_valid = r_valid;
`endif

    // A fresh drop outranks a clear arriving in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overrun <= 1'b0;
        end else if (w_drop) begin
            r_overrun <= 1'b1;
        end else if (io_overrun_clear) begin
            r_overrun <= 1'b0;
        end
    end

    assign io_rsp_valid         = w_rsp_valid;
    assign io_rsp_data          = w_rsp_word.data;
    assign io_rsp_parity_error  = w_rsp_word.parity_error;
    assign io_rsp_framing_error = w_rsp_word.framing_error;
    assign io_overrun           = r_overrun;
    assign io_busy              = (r_state != IDLE);

endmodule

// File: tb/tb_uart_frame_receiver.sv
// Directed plus randomized bench for uart_frame_receiver against a frame-level model.
module tb_uart_frame_receiver;

    localparam int DW = 16;
    localparam int FD = 4;
`ifdef UART_RX_FIFO_EN
    localparam int CAP = FD;
`else
    localparam int CAP = 1;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          io_rx = 1'b1;
    logic [DW-1:0] io_divisor = 16'd5;
    logic          io_parity_en = 1'b0;
    logic          io_rsp_valid;
    logic          io_rsp_ready = 1'b1;
    logic [7:0]    io_rsp_data;
    logic          io_rsp_parity_error;
    logic          io_rsp_framing_error;
    logic          io_overrun;
    logic          io_overrun_clear = 1'b0;
    logic          io_busy;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int rise_cyc = -1;
    logic prev_valid = 1'b0;
    logic [9:0] rcv[$];

    uart_frame_receiver #(
        .DIVISOR_WIDTH (DW),
        .FIFO_DEPTH    (FD)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .io_rx                (io_rx),
        .io_divisor           (io_divisor),
        .io_parity_en         (io_parity_en),
        .io_rsp_valid         (io_rsp_valid),
        .io_rsp_ready         (io_rsp_ready),
        .io_rsp_data          (io_rsp_data),
        .io_rsp_parity_error  (io_rsp_parity_error),
        .io_rsp_framing_error (io_rsp_framing_error),
        .io_overrun           (io_overrun),
        .io_overrun_clear     (io_overrun_clear),
        .io_busy              (io_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!reset && io_rsp_valid && io_rsp_ready)
            rcv.push_back({io_rsp_data, io_rsp_parity_error, io_rsp_framing_error});
        if (io_rsp_valid && !prev_valid)
            rise_cyc = cyc;
        prev_valid = io_rsp_valid;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // Expected {data, perr, ferr} straight from the frame contents.
    function automatic logic [9:0] model(input logic [7:0] d, input bit par,
                                         input bit pbit, input bit stop);
        logic perr;
        perr = par && (($countones(d) % 2) != int'(pbit));
        return {d, perr, ~stop};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic b, input int div);
        io_rx = b;
        repeat (div + 1) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        io_rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Line is left low after a 0 stop bit so a break can be extended.
    task automatic send_frame(input logic [7:0] d, input bit par, input bit pbit,
                              input bit stop, input int div, output int c0);
        io_divisor   = DW'(div);
        io_parity_en = par;
        c0 = cyc;
        drive_bit(1'b0, div);
        for (int i = 0; i < 8; i++) drive_bit(d[i], div);
        if (par) drive_bit(pbit, div);
        drive_bit(stop, div);
        if (stop) io_rx = 1'b1;
    endtask

    task automatic expect_byte(input string tag, input logic [9:0] exp);
        int t;
        t = 0;
        while (rcv.size() == 0 && t < 400) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_arrived"}, 32'(rcv.size() != 0), 32'(1));
        if (rcv.size() != 0) check(tag, 32'(rcv.pop_front()), 32'(exp));
    endtask

    initial begin
        int c0;
        logic [7:0] d;
        bit par;
        bit pbit;
        bit stp;
        int div;

        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 32'(io_rsp_valid), 32'(0));
        check("rst_data", 32'(io_rsp_data), 32'(0));
        check("rst_perr", 32'(io_rsp_parity_error), 32'(0));
        check("rst_ferr", 32'(io_rsp_framing_error), 32'(0));
        check("rst_ovr", 32'(io_overrun), 32'(0));
        check("rst_busy", 32'(io_busy), 32'(0));
        reset = 1'b0;
        idle(3);

        // Byte with correct parity, and its valid latency.
        send_frame(8'hA5, 1, 0, 1, 5, c0);
        expect_byte("t1_a5", model(8'hA5, 1, 0, 1));
        check("t1_latency", 32'(rise_cyc), 32'(c0 + 4 + (5 >> 1) + 10 * 6));
        idle(3);

        send_frame(8'h07, 1, 0, 1, 5, c0);
        expect_byte("t2_perr", model(8'h07, 1, 0, 1));
        idle(3);
        send_frame(8'h07, 0, 0, 1, 5, c0);
        expect_byte("t2_nopar", model(8'h07, 0, 0, 1));
        idle(3);

        // Framing error followed by a long break.
        send_frame(8'h3C, 0, 0, 0, 5, c0);
        repeat (40) @(posedge clk);
        #1;
        expect_byte("t3_ferr", model(8'h3C, 0, 0, 0));
        check("t3_single", 32'(rcv.size()), 32'(0));
        idle(5);
        send_frame(8'h5A, 0, 0, 1, 5, c0);
        expect_byte("t3_after", model(8'h5A, 0, 0, 1));
        idle(3);

        // Two-cycle glitch must be rejected as a false start.
        io_divisor = 16'd9;
        io_rx = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        io_rx = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("t4_busy_on", 32'(io_busy), 32'(1));
        repeat (6) @(posedge clk);
        #1;
        check("t4_busy_off", 32'(io_busy), 32'(0));
        idle(10);
        check("t4_no_byte", 32'(rcv.size()), 32'(0));
        check("t4_no_valid", 32'(io_rsp_valid), 32'(0));

        // Back-pressure: storage fills, one byte dropped.
        io_rsp_ready = 1'b0;
        for (int i = 0; i <= CAP; i++) begin
            send_frame(8'(17 * (i + 1)), 0, 0, 1, 5, c0);
            idle(3);
            check("t5_valid", 32'(io_rsp_valid), 32'(1));
            check("t5_head", 32'(io_rsp_data), 32'(8'h11));
            check("t5_ovr", 32'(io_overrun), 32'(i >= CAP));
        end
        io_overrun_clear = 1'b1;
        @(posedge clk);
        #1;
        io_overrun_clear = 1'b0;
        check("t5_ovr_clr", 32'(io_overrun), 32'(0));
        io_rsp_ready = 1'b1;
        for (int i = 0; i < CAP; i++)
            expect_byte("t5_drain", model(8'(17 * (i + 1)), 0, 0, 1));
        idle(5);
        check("t5_no_extra", 32'(rcv.size()), 32'(0));
        check("t5_empty", 32'(io_rsp_valid), 32'(0));

        // Reset in the middle of data bit 4.
        io_divisor = 16'd5;
        io_parity_en = 1'b0;
        drive_bit(1'b0, 5);
        for (int i = 0; i < 4; i++) drive_bit(1'b1, 5);
        io_rx = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("t6_busy_pre", 32'(io_busy), 32'(1));
        reset = 1'b1;
        #2;
        check("t6_rst_busy", 32'(io_busy), 32'(0));
        check("t6_rst_valid", 32'(io_rsp_valid), 32'(0));
        check("t6_rst_data", 32'(io_rsp_data), 32'(0));
        check("t6_rst_ovr", 32'(io_overrun), 32'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(40);
        check("t6_no_byte", 32'(rcv.size()), 32'(0));
        check("t6_idle", 32'(io_busy), 32'(0));
        send_frame(8'h81, 0, 0, 1, 5, c0);
        expect_byte("t6_81", model(8'h81, 0, 0, 1));

        // Random frames against the model.
        for (int n = 0; n < 12; n++) begin
            d    = 8'($urandom);
            par  = 1'($urandom);
            pbit = 1'($urandom);
            stp  = ($urandom % 4) != 0;
            div  = $urandom_range(3, 12);
            idle($urandom_range(2, 6));
            send_frame(d, par, pbit, stp, div, c0);
            if (!stp) begin
                repeat (div) @(posedge clk);
                #1;
                io_rx = 1'b1;
            end
            expect_byte($sformatf("rnd%0d", n), model(d, par, pbit, stp));
        end
        idle(10);
        check("end_no_extra", 32'(rcv.size()), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
